// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds operation codes and FSM state codes used by muldiv_unit and its bench.
package muldiv_pkg;

  typedef logic [1:0] op_t;
  typedef logic [1:0] state_t;

  localparam op_t OP_MULLO = 2'b00;
  localparam op_t OP_MULHU = 2'b01;
  localparam op_t OP_DIVU  = 2'b10;
  localparam op_t OP_REMU  = 2'b11;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RUN  = 2'b01;
  localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/muldiv_step.sv
// One unsigned radix-2 iteration: shift-add multiply or restoring divide.
// Ports: div_i selects divide, acc_i/acc_o 2W accumulator, opb_i operand.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      div_i,
  input  logic [2*DATA_WIDTH-1:0]   acc_i,
  input  logic [DATA_WIDTH-1:0]     opb_i,
  output logic [2*DATA_WIDTH-1:0]   acc_o
);

  localparam int W = DATA_WIDTH;

  logic [W:0]   sum;
  logic [W:0]   shl;
  logic         ge;
  logic [W-1:0] rem;

  always_comb begin
    // Multiply: acc = {hi, multiplier}; add multiplicand into hi
    // when the multiplier LSB is set, then shift right with carry.
    sum = {1'b0, acc_i[2*W-1:W]}
        + (acc_i[0] ? {1'b0, opb_i} : {(W+1){1'b0}});
    // Divide: acc = {remainder, quotient}; shift left one bit and
    // subtract the divisor if it fits. The difference is < 2^W.
    shl = acc_i[2*W-1:W-1];
    ge  = (shl >= {1'b0, opb_i});
    rem = shl[W-1:0] - opb_i;
    if (!div_i) begin
      acc_o = {sum, acc_i[W-1:1]};
    end else if (ge) begin
      acc_o = {rem, acc_i[W-2:0], 1'b1};
    end else begin
      acc_o = {shl[W-1:0], acc_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/DIV unit with register-file write-back.
// Ports: start/op/rs1/rs2/rd in, flush abort, busy, we/waddr/wdata out.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  flush,
  output logic                  busy,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  op_t             op_q, op_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    res_q, res_d;
  logic [2*W-1:0]  acc_step;
  logic            is_div;

  muldiv_step #(
    .DATA_WIDTH(W)
  ) u_step (
    .div_i (op_q[1]),
    .acc_i (acc_q),
    .opb_i (opb_q),
    .acc_o (acc_step)
  );

  assign is_div = op[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          op_d  = op;
          rd_d  = rd_addr;
          cnt_d = CW'(W-1);
          opb_d = is_div ? rs2_data : rs1_data;
          acc_d = {{W{1'b0}}, (is_div ? rs1_data : rs2_data)};
          if (is_div && (rs2_data == '0)) begin
            res_d   = op[0] ? rs1_data : {W{1'b1}};
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            // op[0] picks the upper half: MULHU product high, REMU rem.
            res_d   = op_q[0] ? acc_step[2*W-1:W] : acc_step[W-1:0];
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  // Flush during DONE suppresses the write in that same cycle.
  assign we    = (state_q == ST_DONE) && !flush;
  assign waddr = (state_q == ST_DONE) ? rd_q  : '0;
  assign wdata = (state_q == ST_DONE) ? res_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus corner sequences.
// Latency counts cycles from the start edge (inclusive) to we high.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   op;
  logic [W-1:0] rs1, rs2;
  logic [A-1:0] rd;
  logic         busy, we;
  logic [A-1:0] waddr;
  logic [W-1:0] wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .DATA_WIDTH(W),
    .ADDR_WIDTH(A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1_data (rs1),
    .rs2_data (rs2),
    .rd_addr  (rd),
    .flush    (flush),
    .busy     (busy),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [A-1:0] rd;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns #1 after the start edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [A-1:0] r);
    op = o; rs1 = a; rs2 = b; rd = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_we(output int lat);
    lat = 1;
    while (!we && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic watch(input int n, output int writes);
    writes = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (we) writes++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    issue(v.op, v.a, v.b, v.rd);
    chk($sformatf("v%0d busy", idx), busy, 1);
    wait_we(lat);
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d waddr", idx), waddr, v.rd);
    chk($sformatf("v%0d wdata", idx), wdata, v.exp);
    @(posedge clk); #1;
    chk($sformatf("v%0d we pulse", idx), we, 0);
    chk($sformatf("v%0d idle", idx), busy, 0);
    @(negedge clk);
  endtask

  initial begin
    int lat, writes, wl;
    logic [W-1:0] wd;
    logic [A-1:0] wa;

    vecs[0]  = '{OP_MULLO, 32'd5, 32'd6, 5'd3, 32'd30, 33};
    vecs[1]  = '{OP_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'd1, 33};
    vecs[2]  = '{OP_MULLO, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{OP_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 33};
    vecs[4]  = '{OP_REMU, 32'd100, 32'd7, 5'd8, 32'd2, 33};
    vecs[5]  = '{OP_DIVU, 32'd9, 32'd0, 5'd10, 32'hFFFF_FFFF, 1};
    vecs[6]  = '{OP_REMU, 32'd9, 32'd0, 5'd11, 32'd9, 1};
    vecs[7]  = '{OP_MULHU, 32'h8000_0000, 32'h8000_0000, 5'd12,
                 32'h4000_0000, 33};
    vecs[8]  = '{OP_MULLO, 32'h1234_5678, 32'h10, 5'd13,
                 32'h2345_6780, 33};
    vecs[9]  = '{OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd14, 32'hFFFF_FFFF, 33};
    vecs[10] = '{OP_REMU, 32'hFFFF_FFFF, 32'h10, 5'd15, 32'hF, 33};
    vecs[11] = '{OP_DIVU, 32'd5, 32'd7, 5'd16, 32'd0, 33};
    vecs[12] = '{OP_REMU, 32'd5, 32'd7, 5'd17, 32'd5, 33};
    vecs[13] = '{OP_MULLO, 32'd7, 32'd7, 5'd0, 32'd49, 33};

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; rd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset we", we, 0);
    chk("reset waddr", waddr, 0);
    chk("reset wdata", wdata, 0);

    // Start sampled on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Second start while busy must be ignored.
    issue(OP_MULLO, 32'd5, 32'd6, 5'd3);
    writes = 0; wl = 0; wd = '0; wa = '0;
    for (int c = 1; c <= 45; c++) begin
      if (we) begin
        writes++;
        if (writes == 1) begin
          wl = c; wd = wdata; wa = waddr;
        end
      end
      if (c == 10) begin
        op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd9;
        start = 1'b1;
      end
      if (c == 11) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("ignore writes", writes, 1);
    chk("ignore latency", wl, 33);
    chk("ignore wdata", wd, 30);
    chk("ignore waddr", wa, 3);
    @(negedge clk);

    // Reset during RUN cycle 15.
    issue(OP_MULLO, 32'd5, 32'd6, 5'd3);
    repeat (14) begin
      @(posedge clk); #1;
    end
    chk("pre-rst busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst busy", busy, 0);
    chk("rst we", we, 0);
    chk("rst wdata", wdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch(40, writes);
    chk("rst no write", writes, 0);
    @(negedge clk);

    // Flush during RUN cycle 20.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
    repeat (19) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1;
    chk("flush run we", we, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", busy, 0);
    watch(40, writes);
    chk("flush no write", writes, 0);
    @(negedge clk);
    run_vec(vecs[3], 3);

    // Flush in DONE cancels the write pulse.
    issue(OP_MULLO, 32'd5, 32'd6, 5'd3);
    wait_we(lat);
    chk("done flush lat", lat, 33);
    flush = 1'b1;
    #1;
    chk("done flush we", we, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("done flush busy", busy, 0);
    watch(5, writes);
    chk("done flush writes", writes, 0);
    @(negedge clk);
    run_vec(vecs[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
